// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receive engine: parity modes,
// FSM state encoding and the 3-sample majority vote.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side output bundle of uart_rx_param: word handshake plus status pulses.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: a word transfers on every CLOCK edge where rx_valid && rx_ready;
  // rx_data is held stable while rx_valid=1, and rx_valid never drops without ready.
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Rx synchroniser, falling-edge detect, oversample tick counter and mid-bit
// majority vote; produces the decided bit plus decision and boundary strobes.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic Rx,
  input  logic baud_tick,
  input  logic cnt_clr,
  output logic rxs,
  output logic fall,
  output logic bit_val,
  output logic decide,
  output logic boundary
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] S2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic          rx_meta;
  logic          rxs_d;
  logic [CW-1:0] cnt;
  logic          smp0;
  logic          smp1;

  // Flops reset to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (baud_tick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (cnt == S0) smp0 <= rxs;
      if (cnt == S1) smp1 <= rxs;
    end
  end

  // The third sample is the live synchronised level on the decision tick.
  assign fall     = rxs_d & ~rxs;
  assign bit_val  = majority3(smp0, smp1, rxs);
  assign decide   = baud_tick & (cnt == S2);
  assign boundary = baud_tick & (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine: frame FSM, shift register, parity check
// and a single-word holding register with valid/ready handshake.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            CLOCK,
  input  logic            reset,
  input  logic            Rx,
  input  logic            baud_tick,
  uart_rx_param_if.master rx_if,
  output uart_state_e     state_dbg
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  uart_state_e          state;
  uart_state_e          state_n;
  logic                 rxs;
  logic                 fall;
  logic                 bit_val;
  logic                 decide;
  logic                 boundary;
  logic                 cnt_clr;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 stop_idx;
  logic                 complete;
  logic                 frame_hit;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .CLOCK    (CLOCK),
    .reset    (reset),
    .Rx       (Rx),
    .baud_tick(baud_tick),
    .cnt_clr  (cnt_clr),
    .rxs      (rxs),
    .fall     (fall),
    .bit_val  (bit_val),
    .decide   (decide),
    .boundary (boundary)
  );

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    complete  = 1'b0;
    frame_hit = 1'b0;
    case (state)
      ST_IDLE:   if (fall) state_n = ST_START;
      ST_START: begin
        if (decide && bit_val) state_n = ST_IDLE;
        else if (boundary)     state_n = ST_DATA;
      end
      ST_DATA: begin
        if (boundary && bit_idx == LAST_BIT)
          state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (boundary) state_n = ST_STOP;
      // Leaving mid-stop-bit lets a back-to-back start edge be caught.
      ST_STOP: begin
        if (decide) begin
          if (!bit_val) begin
            frame_hit = 1'b1;
            state_n   = ST_BREAK_WAIT;
          end else if (stop_idx == LAST_STOP) begin
            complete = 1'b1;
            state_n  = ST_IDLE;
          end
        end
      end
      ST_BREAK_WAIT: if (rxs) state_n = ST_IDLE;
      default:       state_n = ST_IDLE;
    endcase
  end

  assign cnt_clr = (state == ST_IDLE) || (state_n != state);

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      bit_idx  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          bit_idx  <= '0;
          perr     <= 1'b0;
          stop_idx <= 1'b0;
        end
        ST_DATA: begin
          if (decide)   shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
          if (boundary) bit_idx <= bit_idx + IW'(1);
        end
        ST_PARITY: if (decide) perr <= bit_val ^ (^shreg) ^ (PARITY == PAR_ODD);
        ST_STOP:   if (boundary) stop_idx <= 1'b1;
        default: ;
      endcase
    end
  end

  // A completion into a full, unaccepted holding register drops the new word.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      rx_if.rx_data    <= '0;
      rx_if.rx_valid   <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.overrun    <= 1'b0;
    end else begin
      rx_if.frame_err  <= frame_hit;
      rx_if.parity_err <= 1'b0;
      rx_if.overrun    <= 1'b0;
      if (complete) begin
        if (!rx_if.rx_valid || rx_if.rx_ready) begin
          rx_if.rx_data    <= shreg;
          rx_if.rx_valid   <= 1'b1;
          rx_if.parity_err <= perr;
        end else begin
          rx_if.overrun <= 1'b1;
        end
      end else if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end
    end
  end

  assign rx_if.busy = (state != ST_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) driven from
// serial frame tasks, with a scoreboard of expected words.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = TICK_DIV * OS;

  // ---------------- clock / reset / baud tick ----------------
  logic CLOCK     = 1'b0;
  logic reset     = 1'b1;
  logic baud_tick = 1'b0;
  logic rx_a      = 1'b1;
  logic rx_b      = 1'b1;
  logic rx_c      = 1'b1;
  int   tick_div_cnt = 0;

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    baud_tick    = (tick_div_cnt == TICK_DIV - 1);
    tick_div_cnt = (tick_div_cnt + 1) % TICK_DIV;
  end

  // ---------------- DUTs ----------------
  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(7)) if_c ();
  uart_state_e st_a, st_b, st_c;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u_a (
    .CLOCK(CLOCK), .reset(reset), .Rx(rx_a), .baud_tick(baud_tick), .rx_if(if_a), .state_dbg(st_a)
  );
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1)) u_b (
    .CLOCK(CLOCK), .reset(reset), .Rx(rx_b), .baud_tick(baud_tick), .rx_if(if_b), .state_dbg(st_b)
  );
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(2)) u_c (
    .CLOCK(CLOCK), .reset(reset), .Rx(rx_c), .baud_tick(baud_tick), .rx_if(if_c), .state_dbg(st_c)
  );

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_words[3];
  int   n_ferr[3];
  int   n_ovr[3];
  logic prev_v[3];
  logic prev_r[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] key(input int which, input logic perr, input logic [8:0] d);
    return {2'(which), perr, d};
  endfunction

  // A new word is a load of the holding register: valid rising, or a reload
  // right after an accepted transfer.
  task automatic mon(input int which, input logic v, input logic r, input logic [8:0] d,
                     input logic pe, input logic fe, input logic ov);
    logic new_word;
    new_word = v && (!prev_v[which] || prev_r[which]);
    if (new_word) begin
      n_words[which]++;
      if (exp_q.size() == 0) begin
        check("word_unexpected", 32'(key(which, pe, d)), 32'hFFFF);
      end else begin
        check("word", 32'(key(which, pe, d)), 32'(exp_q.pop_front()));
        check("valid_after_tick", 32'(baud_tick), 32'd1);
      end
    end else if (pe) begin
      check("perr_without_word", 32'd1, 32'd0);
    end
    if (fe) n_ferr[which]++;
    if (ov) n_ovr[which]++;
    prev_v[which] = v;
    prev_r[which] = r;
  endtask

  always begin
    @(posedge CLOCK);
    #1;
    mon(0, if_a.rx_valid, if_a.rx_ready, {1'b0, if_a.rx_data}, if_a.parity_err, if_a.frame_err, if_a.overrun);
    mon(1, if_b.rx_valid, if_b.rx_ready, {1'b0, if_b.rx_data}, if_b.parity_err, if_b.frame_err, if_b.overrun);
    mon(2, if_c.rx_valid, if_c.rx_ready, {2'b0, if_c.rx_data}, if_c.parity_err, if_c.frame_err, if_c.overrun);
  end

  // ---------------- driver tasks ----------------
  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge CLOCK);
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int par_mode, input logic par_flip,
                            input int nstop, input logic [1:0] stop_vals);
    logic p;
    p = 1'b0;
    @(negedge CLOCK);
    set_rx(which, 1'b0);
    hold_bits(1);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, data[i]);
      p = p ^ data[i];
      hold_bits(1);
    end
    if (par_mode != 0) begin
      set_rx(which, p ^ (par_mode == 2) ^ par_flip);
      hold_bits(1);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(which, stop_vals[i]);
      hold_bits(1);
    end
  endtask

  // ---------------- test sequence ----------------
  int w0, f0, o0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      n_words[i] = 0; n_ferr[i] = 0; n_ovr[i] = 0;
      prev_v[i] = 1'b0; prev_r[i] = 1'b0;
    end
    if_a.rx_ready = 1'b1;
    if_b.rx_ready = 1'b1;
    if_c.rx_ready = 1'b1;

    repeat (3) @(negedge CLOCK);
    check("rst_valid", 32'(if_a.rx_valid), 32'd0);
    check("rst_busy",  32'(if_a.busy), 32'd0);
    check("rst_data",  32'(if_a.rx_data), 32'd0);
    check("rst_pulses", 32'({if_a.frame_err, if_a.parity_err, if_a.overrun}), 32'd0);
    check("rst_state", 32'(st_a), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (4) @(negedge CLOCK);

    // 8N1 back-to-back words
    exp_q.push_back(key(0, 1'b0, 9'h055));
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b11);
    exp_q.push_back(key(0, 1'b0, 9'h0A3));
    send_frame(0, 9'h0A3, 8, 0, 1'b0, 1, 2'b11);
    hold_bits(2);
    check("t1_words", 32'(n_words[0]), 32'd2);
    check("t1_ferr",  32'(n_ferr[0]), 32'd0);
    check("t1_busy",  32'(if_a.busy), 32'd0);
    check("t1_q",     32'(exp_q.size()), 32'd0);

    // Short low glitch is a false start
    w0 = n_words[0];
    set_rx(0, 1'b0);
    repeat (5 * TICK_DIV) @(negedge CLOCK);
    check("t2_busy_start", 32'(if_a.busy), 32'd1);
    set_rx(0, 1'b1);
    hold_bits(2);
    check("t2_busy_idle", 32'(if_a.busy), 32'd0);
    check("t2_no_word", 32'(n_words[0]), 32'(w0));
    check("t2_no_ferr", 32'(n_ferr[0]), 32'd0);

    // Even parity: wrong parity bit, then correct one
    exp_q.push_back(key(1, 1'b1, 9'h007));
    send_frame(1, 9'h007, 8, 1, 1'b1, 1, 2'b11);
    exp_q.push_back(key(1, 1'b0, 9'h007));
    send_frame(1, 9'h007, 8, 1, 1'b0, 1, 2'b11);
    exp_q.push_back(key(1, 1'b0, 9'h0C3));
    send_frame(1, 9'h0C3, 8, 1, 1'b0, 1, 2'b11);
    hold_bits(2);
    check("t3_words", 32'(n_words[1]), 32'd3);
    check("t3_q", 32'(exp_q.size()), 32'd0);

    // Bad stop bit followed by a line break
    f0 = n_ferr[0];
    w0 = n_words[0];
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b00);
    hold_bits(20);
    check("t4_ferr", 32'(n_ferr[0] - f0), 32'd1);
    check("t4_busy_break", 32'(if_a.busy), 32'd1);
    check("t4_state", 32'(st_a), 32'(ST_BREAK_WAIT));
    check("t4_no_word", 32'(n_words[0]), 32'(w0));
    set_rx(0, 1'b1);
    hold_bits(1);
    check("t4_busy_rel", 32'(if_a.busy), 32'd0);
    exp_q.push_back(key(0, 1'b0, 9'h081));
    send_frame(0, 9'h081, 8, 0, 1'b0, 1, 2'b11);
    hold_bits(2);
    check("t4_recover", 32'(n_words[0]), 32'(w0 + 1));

    // Consumer stalled: second word overruns
    if_a.rx_ready = 1'b0;
    o0 = n_ovr[0];
    exp_q.push_back(key(0, 1'b0, 9'h011));
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11);
    hold_bits(1);
    check("t5_ovr", 32'(n_ovr[0] - o0), 32'd1);
    check("t5_data", 32'(if_a.rx_data), 32'h11);
    check("t5_valid", 32'(if_a.rx_valid), 32'd1);
    if_a.rx_ready = 1'b1;
    @(posedge CLOCK);
    #1;
    check("t5_valid_drop", 32'(if_a.rx_valid), 32'd0);
    @(negedge CLOCK);

    // 7N2: good word held, then second stop bit 0
    if_c.rx_ready = 1'b0;
    exp_q.push_back(key(2, 1'b0, 9'h05A));
    send_frame(2, 9'h05A, 7, 0, 1'b0, 2, 2'b11);
    hold_bits(1);
    check("t6_valid", 32'(if_c.rx_valid), 32'd1);
    f0 = n_ferr[2];
    w0 = n_words[2];
    send_frame(2, 9'h05A, 7, 0, 1'b0, 2, 2'b01);
    hold_bits(1);
    check("t6_ferr", 32'(n_ferr[2] - f0), 32'd1);
    check("t6_no_word", 32'(n_words[2]), 32'(w0));
    check("t6_no_ovr", 32'(n_ovr[2]), 32'd0);
    set_rx(2, 1'b1);
    hold_bits(1);
    check("t6_idle", 32'(if_c.busy), 32'd0);

    // Reset in the middle of the data bits
    set_rx(2, 1'b0);
    hold_bits(1);
    set_rx(2, 1'b1);
    hold_bits(1);
    set_rx(2, 1'b0);
    hold_bits(1);
    check("t6_pre_state", 32'(st_c), 32'(ST_DATA));
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(if_c.rx_valid), 32'd0);
    check("t6_rst_busy", 32'(if_c.busy), 32'd0);
    check("t6_rst_data", 32'(if_c.rx_data), 32'd0);
    check("t6_rst_pulses", 32'({if_c.frame_err, if_c.parity_err, if_c.overrun}), 32'd0);
    set_rx(2, 1'b1);
    repeat (4) @(negedge CLOCK);
    reset = 1'b0;
    if_c.rx_ready = 1'b1;
    hold_bits(1);
    w0 = n_words[2];
    exp_q.push_back(key(2, 1'b0, 9'h02B));
    send_frame(2, 9'h02B, 7, 0, 1'b0, 2, 2'b11);
    hold_bits(2);
    check("t6_recover", 32'(n_words[2]), 32'(w0 + 1));

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive engine and next-generation replacement for the fixed 8N1 receive FSM. It is self-contained: input synchroniser, oversample tick counter, 3-sample majority vote, shift register and output holding register, with no external counter or ROM. It supports configurable data width, optional parity and 1 or 2 stop bits. It delivers bytes over a valid/ready handshake and reports framing, parity and overrun errors. It sits between the board Rx pin and the Forth core's input FIFO.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, baud_tick strobes per bit period, legal 8..32, must be even
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, 1 or 2

Ports:
CLOCK  in  1  system clock
reset  in  1  asynchronous, active-high reset
Rx  in  1  raw serial line, asynchronous, idle high
baud_tick  in  1  one-CLOCK strobe at OVERSAMPLE x baud rate
rx_data  out  DATA_BITS  received word, valid while rx_valid=1
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts rx_data on a CLOCK edge where rx_valid&rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled 0
parity_err  out  1  one-cycle pulse: parity mismatch, concurrent with rx_valid rise/reload
overrun  out  1  one-cycle pulse: completed word dropped because holding register full
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state=IDLE, rx_data=0, rx_valid=0, all pulses=0, busy=0, tick count=0, synchroniser flops=1.
- Rx passes through a 2-flop synchroniser (rxs). Falling edge = previous rxs 1 and current rxs 0, evaluated every CLOCK.
- The tick counter cnt (0..OVERSAMPLE-1) advances only on baud_tick and clears on state entry.
- Samples are taken at cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three, resolved on the tick at cnt = OVERSAMPLE/2+1 (the "decision tick").
- IDLE: on a falling edge, go to START with cnt=0.
- START: on the decision tick, a bit of 1 is a false start and returns to IDLE with no flag. A bit of 0 is valid: go to DATA at the next bit boundary (tick with cnt=OVERSAMPLE-1), with bit index=0.
- DATA: shift the decided bit in LSB first on each decision tick. At the boundary after bit DATA_BITS-1, go to PARITY if PARITY!=0, else to STOP.
- PARITY: decide the bit. Mismatch against the XOR of the data (inverted for odd parity) sets an internal perr flag. Go to STOP at the boundary.
- STOP: on the decision tick of each stop bit:
  - If the bit is 0: pulse frame_err, discard the word, go to BREAK_WAIT.
  - If the bit is 1 and it is the last stop bit: complete the word on the same CLOCK edge and go directly to IDLE. IDLE is entered mid-stop-bit so a back-to-back start bit is caught.
  - If the bit is 1 and 2 stop bits are configured: continue to the second stop bit at the boundary.
- BREAK_WAIT: stay until rxs=1 (a plain synchronised level, no tick needed), then go to IDLE. This covers line-break recovery.
- Word completion, on the edge after the final decision:
  - rx_valid=0, or rx_ready=1 in the same cycle: load rx_data, set rx_valid=1, pulse parity_err if perr.
  - rx_valid=1 and rx_ready=0: keep the old rx_data, pulse overrun. parity_err is not pulsed for the dropped word.
- Handshake: rx_valid clears on the edge where rx_valid&rx_ready, unless a completion reloads it in the same cycle. rx_data is stable while rx_valid=1.
- Latency: rx_valid rises exactly 1 CLOCK after the decision tick of the last stop bit.
- baud_tick absent: the FSM stalls in place and the synchroniser keeps running.
- Reset mid-frame: abort immediately, no flags, rx_valid cleared.

Decomposition:
- Shared package uart_pkg:
  - parity encodings PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - state encodings IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
  - function majority3
- Sub-module uart_rx_sampler: synchroniser, falling-edge detect, tick counter, 3-sample majority vote. Outputs bit value, decision strobe and boundary strobe.
- The top level holds the FSM, shift register, parity check and output handshake.

Test Plan:
1. Defaults (8N1, OS=16), rx_ready=1, send 0x55 then 0xA3 -> two rx_valid pulses with rx_data=0x55 then 0xA3, no flags, each rx_valid 1 CLOCK after the stop decision tick.
2. Rx glitches low for 5 ticks then returns high -> false start, back to IDLE, no rx_valid, busy drops to 0.
3. PARITY=1 (even), send 0x07 with parity bit 0 -> rx_valid with rx_data=0x07 and a concurrent parity_err pulse. Repeat with parity bit 1 -> no parity_err.
4. Send 0x3C with stop bit 0, then hold Rx low 20 bit-times -> frame_err pulse, no rx_valid, busy stays high until Rx goes high, then the next frame 0x81 is received correctly.
5. rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses at the second completion. Raise rx_ready -> rx_valid drops the next cycle.
6. STOP_BITS=2, DATA_BITS=7, send 0x5A with the second stop bit 0 -> frame_err, no rx_valid. Assert reset mid-DATA in a separate frame -> all outputs 0 immediately.
